alu_exec_unit: RTL and testbench

Parametrised, handshaked execution unit that decodes RISC-V ALU control fields (ALUOp, funct3, funct7, op5) and computes the result over multiple cycles where needed. It replaces the purely combinational ALU-control path with a registered decoder/ALU pair. Single-cycle ops finish one cycle after acceptance. Shifts iterate one bit per cycle; the optional multiply is shift-add. It sits between the register-read stage and writeback/branch logic of the multi-cycle core.

---
 rtl/alu_exec_unit.sv | 191 +++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - handshaked RISC-V ALU decode/execute unit with iterative shifts
// Optional shift-add multiply compiled in when ALU_MUL_EN is defined.
module alu_exec_unit #(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            op5,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [3:0]      alu_ctrl,
  output logic            err
);

  localparam logic [3:0] C_ADD = 4'b0000, C_SUB = 4'b0001, C_AND = 4'b0010,
                         C_OR  = 4'b0011, C_XOR = 4'b0100, C_SLT = 4'b0101,
                         C_SLTU = 4'b0110, C_SLL = 4'b0111, C_SRL = 4'b1000,
                         C_SRA = 4'b1001, C_MUL = 4'b1010, C_ILL = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_t;

  state_t          state;
  logic [3:0]      ctrl;
  logic [XLEN-1:0] acc;
  logic [SHW-1:0]  cnt;
`ifdef ALU_MUL_EN
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] mul_nxt;
`endif

  logic [3:0]      dec;
  logic [XLEN-1:0] alu_val;
  logic [XLEN-1:0] shift_nxt;
  logic [SHW-1:0]  shamt;
  logic            is_shift;

  assign shamt    = src_b[SHW-1:0];
  assign is_shift = (dec == C_SLL) || (dec == C_SRL) || (dec == C_SRA);

  always_comb begin
    dec = C_ILL;
    case (alu_op)
      2'b00: dec = C_ADD;
      2'b01: dec = C_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  dec = ({op5, funct7[5]} == 2'b11) ? C_SUB : C_ADD;
          3'b001:  dec = C_SLL;
          3'b010:  dec = C_SLT;
          3'b011:  dec = C_SLTU;
          3'b100:  dec = C_XOR;
          3'b101:  dec = funct7[5] ? C_SRA : C_SRL;
          3'b110:  dec = C_OR;
          default: dec = C_AND;
        endcase
        if (op5 && funct7 == 7'b0000001 && funct3 == 3'b000) begin
`ifdef ALU_MUL_EN
          dec = C_MUL;
`else
          dec = C_ILL;
`endif
        end
      end
      default: dec = C_ILL;
    endcase
  end

  // Shift codes yield src_a here; only used directly when the shift amount is 0.
  always_comb begin
    alu_val = '0;
    case (dec)
      C_ADD:  alu_val = src_a + src_b;
      C_SUB:  alu_val = src_a - src_b;
      C_AND:  alu_val = src_a & src_b;
      C_OR:   alu_val = src_a | src_b;
      C_XOR:  alu_val = src_a ^ src_b;
      C_SLT:  alu_val = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      C_SLTU: alu_val = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      C_SLL, C_SRL, C_SRA: alu_val = src_a;
      default: alu_val = '0;
    endcase
  end

  always_comb begin
    shift_nxt = {acc[XLEN-1], acc[XLEN-1:1]};
    if (ctrl == C_SLL) shift_nxt = {acc[XLEN-2:0], 1'b0};
    else if (ctrl == C_SRL) shift_nxt = {1'b0, acc[XLEN-1:1]};
  end

`ifdef ALU_MUL_EN
  assign mul_nxt = mplier[0] ? acc + mcand : acc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      alu_ctrl  <= 4'b0000;
      err       <= 1'b0;
      ctrl      <= 4'b0000;
      acc       <= '0;
      cnt       <= '0;
`ifdef ALU_MUL_EN
      mcand     <= '0;
      mplier    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            ctrl     <= dec;
            if (is_shift && shamt != '0) begin
              state <= S_SHIFT;
              acc   <= src_a;
              cnt   <= shamt - 1'b1;
            end
`ifdef ALU_MUL_EN
            else if (dec == C_MUL) begin
              state  <= S_MUL;
              acc    <= '0;
              mcand  <= src_a;
              mplier <= src_b;
              cnt    <= SHW'(XLEN - 1);
            end
`endif
            else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              result    <= alu_val;
              zero      <= (alu_val == '0);
              alu_ctrl  <= dec;
              err       <= (dec == C_ILL);
            end
          end
        end
        S_SHIFT: begin
          acc <= shift_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            result    <= shift_nxt;
            zero      <= (shift_nxt == '0);
            alu_ctrl  <= ctrl;
            err       <= 1'b0;
          end
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          acc    <= mul_nxt;
          mcand  <= {mcand[XLEN-2:0], 1'b0};
          mplier <= {1'b0, mplier[XLEN-1:1]};
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            result    <= mul_nxt;
            zero      <= (mul_nxt == '0);
            alu_ctrl  <= ctrl;
            err       <= 1'b0;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        op5;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic [3:0]  alu_ctrl;
  logic        err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  ctrl;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  alu_exec_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .op5(op5),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .alu_ctrl(alu_ctrl), .err(err)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] r, input logic [3:0] c, input logic e, input int l);
    exp_t x;
    x.res = r; x.ctrl = c; x.err = e; x.lat = l;
    return x;
  endfunction

  function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic o5, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = mk(32'h0, 4'hF, 1'b0, 1);
    if (op == 2'b00) begin e.ctrl = 4'h0; e.res = a + b; end
    else if (op == 2'b01) begin e.ctrl = 4'h1; e.res = a - b; end
    else if (op == 2'b11) e.err = 1'b1;
    else if (o5 && f7 == 7'h01 && f3 == 3'b000) begin
`ifdef ALU_MUL_EN
      e.ctrl = 4'hA; e.res = a * b; e.lat = 33;
`else
      e.err = 1'b1;
`endif
    end else begin
      case (f3)
        3'd0: if (o5 && f7[5]) begin e.ctrl = 4'h1; e.res = a - b; end
              else begin e.ctrl = 4'h0; e.res = a + b; end
        3'd1: begin e.ctrl = 4'h7; e.res = a << b[4:0]; e.lat = 1 + int'(b[4:0]); end
        3'd2: begin e.ctrl = 4'h5; e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        3'd3: begin e.ctrl = 4'h6; e.res = (a < b) ? 32'd1 : 32'd0; end
        3'd4: begin e.ctrl = 4'h4; e.res = a ^ b; end
        3'd5: begin
          e.lat = 1 + int'(b[4:0]);
          if (f7[5]) begin e.ctrl = 4'h9; e.res = $signed(a) >>> b[4:0]; end
          else begin e.ctrl = 4'h8; e.res = a >> b[4:0]; end
        end
        3'd6: begin e.ctrl = 4'h3; e.res = a | b; end
        default: begin e.ctrl = 4'h2; e.res = a & b; end
      endcase
    end
    return e;
  endfunction

  task automatic send_op(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic o5, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int t = 0;
    while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
    checks++;
    if (!in_ready) begin failures++; $display("FAIL in_ready_timeout got=%0b want=1", in_ready); end
    alu_op = op; funct3 = f3; funct7 = f7; op5 = o5; src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(e);
  endtask

  task automatic recv_op(input string name, input bit drain);
    exp_t e;
    int lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    e = sb.pop_front();
    checks += 5;
    if (lat !== e.lat) begin failures++; $display("FAIL %s latency got=%0d want=%0d", name, lat, e.lat); end
    if (result !== e.res) begin failures++; $display("FAIL %s result got=%h want=%h", name, result, e.res); end
    if (alu_ctrl !== e.ctrl) begin failures++; $display("FAIL %s alu_ctrl got=%b want=%b", name, alu_ctrl, e.ctrl); end
    if (err !== e.err) begin failures++; $display("FAIL %s err got=%b want=%b", name, err, e.err); end
    if (zero !== (e.res == 32'h0)) begin failures++; $display("FAIL %s zero got=%b want=%b", name, zero, e.res == 32'h0); end
    if (drain) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks += 2;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL %s drain_valid got=%b want=0", name, out_valid); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL %s drain_ready got=%b want=1", name, in_ready); end
    end
  endtask

  task automatic check_reset_outs(input string name);
    checks += 6;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL %s in_ready got=%b want=1", name, in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL %s out_valid got=%b want=0", name, out_valid); end
    if (result !== 32'h0) begin failures++; $display("FAIL %s result got=%h want=0", name, result); end
    if (zero !== 1'b1) begin failures++; $display("FAIL %s zero got=%b want=1", name, zero); end
    if (alu_ctrl !== 4'h0) begin failures++; $display("FAIL %s alu_ctrl got=%b want=0", name, alu_ctrl); end
    if (err !== 1'b0) begin failures++; $display("FAIL %s err got=%b want=0", name, err); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("reset_held");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("reset_released");
  endtask

  task automatic test_arith();
    send_op(2'b10, 3'b000, 7'b0100000, 1'b1, 32'd5, 32'd7, mk(32'hFFFFFFFE, 4'h1, 1'b0, 1));
    recv_op("sub_r", 1);
    send_op(2'b10, 3'b010, 7'b0100000, 1'b1, 32'd5, 32'd7, mk(32'h1, 4'h5, 1'b0, 1));
    recv_op("slt_r", 1);
    send_op(2'b01, 3'b000, 7'b0, 1'b0, 32'd3, 32'd3, mk(32'h0, 4'h1, 1'b0, 1));
    recv_op("sub_zero", 1);
    send_op(2'b10, 3'b000, 7'b0100000, 1'b0, 32'd5, 32'd7, mk(32'd12, 4'h0, 1'b0, 1));
    recv_op("addi_f7", 1);
  endtask

  task automatic test_shift();
    send_op(2'b10, 3'b101, 7'b0100000, 1'b1, 32'h80000000, 32'd4, mk(32'hF8000000, 4'h9, 1'b0, 5));
    recv_op("sra4", 1);
    send_op(2'b10, 3'b001, 7'b0, 1'b1, 32'h12345678, 32'd0, mk(32'h12345678, 4'h7, 1'b0, 1));
    recv_op("sll0", 1);
    send_op(2'b10, 3'b101, 7'b0, 1'b1, 32'h80000000, 32'd31, mk(32'h1, 4'h8, 1'b0, 32));
    recv_op("srl31", 1);
  endtask

  task automatic test_illegal_mul();
    send_op(2'b11, 3'b000, 7'b0, 1'b1, 32'd9, 32'd9, mk(32'h0, 4'hF, 1'b1, 1));
    recv_op("illegal", 1);
`ifdef ALU_MUL_EN
    send_op(2'b10, 3'b000, 7'b0000001, 1'b1, 32'hFFFFFFFF, 32'd3, mk(32'hFFFFFFFD, 4'hA, 1'b0, 33));
`else
    send_op(2'b10, 3'b000, 7'b0000001, 1'b1, 32'hFFFFFFFF, 32'd3, mk(32'h0, 4'hF, 1'b1, 1));
`endif
    recv_op("mul", 1);
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    send_op(2'b00, 3'b000, 7'b0, 1'b0, 32'd100, 32'd23, mk(32'd123, 4'h0, 1'b0, 1));
    recv_op("bp_op", 0);
    held = result;
    alu_op = 2'b00; src_a = 32'd1; src_b = 32'd1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks += 3;
      if (result !== held) begin failures++; $display("FAIL bp_stable cyc=%0d got=%h want=%h", i, result, held); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, in_ready); end
      if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid cyc=%0d got=%b want=1", i, out_valid); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_queue got=%b want=0", out_valid); end
  endtask

  task automatic test_ready_high();
    out_ready = 1'b1;
    send_op(2'b00, 3'b000, 7'b0, 1'b0, 32'd7, 32'd8, mk(32'd15, 4'h0, 1'b0, 1));
    recv_op("rdy_high", 0);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rdy_high_one_cycle got=%b want=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    send_op(2'b10, 3'b001, 7'b0, 1'b1, 32'h1, 32'd20, mk(32'h0, 4'h0, 1'b0, 0));
    void'(sb.pop_back());
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outs("midop_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_op(2'b00, 3'b000, 7'b0, 1'b0, 32'd1, 32'd1, mk(32'd2, 4'h0, 1'b0, 1));
    recv_op("after_reset", 1);
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        o5;
    logic [31:0] a, b;
    logic [6:0]  f7s [3];
    f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      f3 = 3'($urandom);
      f7 = f7s[$urandom_range(0, 2)];
      o5 = 1'($urandom);
      a = $urandom;
      b = (i % 3 == 0) ? a : $urandom;
      send_op(op, f3, f7, o5, a, b, model(op, f3, f7, o5, a, b));
      recv_op("random", 1);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 2'b00; funct3 = 3'b000; funct7 = 7'b0; op5 = 1'b0; src_a = '0; src_b = '0;
    test_reset();
    test_arith();
    test_shift();
    test_illegal_mul();
    test_backpressure();
    test_ready_high();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
